// File: rtl/snn_pkg.sv
// Shared SNN definitions: dispatcher FSM states, synapse table entry, default widths.
package snn_pkg;

  localparam int unsigned SNN_ID_WIDTH     = 16;
  localparam int unsigned SNN_WEIGHT_WIDTH = 8;

  typedef enum logic [1:0] {
    DISP_IDLE = 2'd0,
    DISP_SCAN = 2'd1,
    DISP_EMIT = 2'd2
  } disp_state_t;

  typedef struct packed {
    logic                        en;
    logic [SNN_ID_WIDTH-1:0]     dest;
    logic [SNN_WEIGHT_WIDTH-1:0] weight;
  } syn_entry_t;

  // Index width that never collapses to zero bits for single-entry tables.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spike_synapse_dispatcher_if.sv
// Event-in / synapse-out handshake bundle of the spike dispatcher.
interface spike_synapse_dispatcher_if
  import snn_pkg::*;
#(
  parameter int unsigned ID_WIDTH     = SNN_ID_WIDTH,
  parameter int unsigned WEIGHT_WIDTH = SNN_WEIGHT_WIDTH
) ();

  logic                    ev_valid;
  logic                    ev_ready;
  logic [ID_WIDTH-1:0]     ev_src_id;
  logic                    syn_valid;
  logic                    syn_ready;
  logic [ID_WIDTH-1:0]     syn_dest_id;
  logic [ID_WIDTH-1:0]     syn_src_id;
  logic [WEIGHT_WIDTH-1:0] syn_weight;

  modport slave (
    input  ev_valid, ev_src_id, syn_ready,
    output ev_ready, syn_valid, syn_dest_id, syn_src_id, syn_weight
  );

  modport master (
    output ev_valid, ev_src_id, syn_ready,
    input  ev_ready, syn_valid, syn_dest_id, syn_src_id, syn_weight
  );

endinterface

// File: rtl/spike_event_fifo.sv
// Synchronous count-based FIFO for spike events; push and pop may coincide at any occupancy.
module spike_event_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/spike_synapse_dispatcher.sv
// Presynaptic fan-out: buffers fired-spike events and emits one transaction per enabled synapse.
// Optional DISPATCH_STATS_EN adds stat_events / stat_syn counters.
module spike_synapse_dispatcher
  import snn_pkg::*;
#(
  parameter int unsigned NUM_SRC      = 16,
  parameter int unsigned FANOUT_MAX   = 4,
  parameter int unsigned ID_WIDTH     = SNN_ID_WIDTH,
  parameter int unsigned WEIGHT_WIDTH = SNN_WEIGHT_WIDTH,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  spike_synapse_dispatcher_if.slave            bus,
  input  logic                                 cfg_we,
  input  logic [clog2_min1(NUM_SRC)-1:0]       cfg_src,
  input  logic [clog2_min1(FANOUT_MAX)-1:0]    cfg_slot,
  input  logic                                 cfg_en,
  input  logic [ID_WIDTH-1:0]                  cfg_dest,
  input  logic [WEIGHT_WIDTH-1:0]              cfg_weight,
  output logic                                 busy,
  output logic [15:0]                          drop_count
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]                          stat_events,
  output logic [31:0]                          stat_syn
`endif
);

  localparam int unsigned         SRC_W      = clog2_min1(NUM_SRC);
  localparam int unsigned         SLOT_W     = clog2_min1(FANOUT_MAX);
  localparam logic [SLOT_W-1:0]   LAST_SLOT  = SLOT_W'(FANOUT_MAX - 1);
  localparam logic [ID_WIDTH-1:0] SRC_LIMIT  = ID_WIDTH'(NUM_SRC);
  localparam logic [SRC_W:0]      CFG_SRC_LIM  = (SRC_W+1)'(NUM_SRC);
  localparam logic [SLOT_W:0]     CFG_SLOT_LIM = (SLOT_W+1)'(FANOUT_MAX);

  disp_state_t             r_state;
  disp_state_t             w_next_state;
  logic [SRC_W-1:0]        r_cur_src;
  logic [SLOT_W-1:0]       r_slot;
  syn_entry_t              r_table [NUM_SRC][FANOUT_MAX];
  syn_entry_t              w_entry;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic [ID_WIDTH-1:0]     w_head;
  logic                    w_latch_src;
  logic                    w_slot_inc;
  logic                    w_load_syn;
  logic                    w_syn_done;
  logic                    w_drop;
  logic                    r_syn_valid;
  logic [ID_WIDTH-1:0]     r_syn_dest;
  logic [ID_WIDTH-1:0]     r_syn_src;
  logic [WEIGHT_WIDTH-1:0] r_syn_weight;
  logic [15:0]             r_drop_count;

  assign w_push   = bus.ev_valid && !w_full;
  assign w_entry  = r_table[r_cur_src][r_slot];

  spike_event_fifo #(
    .WIDTH (ID_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (bus.ev_src_id),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < NUM_SRC; s++)
        for (int unsigned f = 0; f < FANOUT_MAX; f++)
          r_table[s][f] <= '0;
    end else if (cfg_we && ({1'b0, cfg_src} < CFG_SRC_LIM) && ({1'b0, cfg_slot} < CFG_SLOT_LIM)) begin
      r_table[cfg_src][cfg_slot] <= '{en: cfg_en, dest: cfg_dest, weight: cfg_weight};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= DISP_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_latch_src  = 1'b0;
    w_slot_inc   = 1'b0;
    w_load_syn   = 1'b0;
    w_syn_done   = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      DISP_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head < SRC_LIMIT) begin
            w_latch_src  = 1'b1;
            w_next_state = DISP_SCAN;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      DISP_SCAN: begin
        if (w_entry.en) begin
          w_load_syn   = 1'b1;
          w_next_state = DISP_EMIT;
        end else if (r_slot == LAST_SLOT) begin
          w_next_state = DISP_IDLE;
        end else begin
          w_slot_inc = 1'b1;
        end
      end
      DISP_EMIT: begin
        // syn_valid is always high in EMIT, so syn_ready alone completes the handshake.
        if (bus.syn_ready) begin
          w_syn_done = 1'b1;
          if (r_slot == LAST_SLOT) begin
            w_next_state = DISP_IDLE;
          end else begin
            w_slot_inc   = 1'b1;
            w_next_state = DISP_SCAN;
          end
        end
      end
      default: w_next_state = DISP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_src    <= '0;
      r_slot       <= '0;
      r_syn_valid  <= 1'b0;
      r_syn_dest   <= '0;
      r_syn_src    <= '0;
      r_syn_weight <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_latch_src) begin
        r_cur_src <= w_head[SRC_W-1:0];
        r_slot    <= '0;
      end else if (w_slot_inc) begin
        r_slot <= r_slot + SLOT_W'(1);
      end
      if (w_load_syn) begin
        r_syn_valid  <= 1'b1;
        r_syn_dest   <= w_entry.dest;
        r_syn_src    <= ID_WIDTH'(r_cur_src);
        r_syn_weight <= w_entry.weight;
      end else if (w_syn_done) begin
        r_syn_valid <= 1'b0;
      end
      if (w_drop && (r_drop_count != '1)) r_drop_count <= r_drop_count + 16'd1;
    end
  end

`ifdef DISPATCH_STATS_EN
  logic [31:0] r_stat_events;
  logic [31:0] r_stat_syn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_events <= '0;
      r_stat_syn    <= '0;
    end else begin
      if (w_latch_src) r_stat_events <= r_stat_events + 32'd1;
      if (w_syn_done)  r_stat_syn    <= r_stat_syn + 32'd1;
    end
  end

  assign stat_events = r_stat_events;
  assign stat_syn    = r_stat_syn;
`endif

  assign bus.ev_ready    = !w_full;
  assign bus.syn_valid   = r_syn_valid;
  assign bus.syn_dest_id = r_syn_dest;
  assign bus.syn_src_id  = r_syn_src;
  assign bus.syn_weight  = r_syn_weight;
  assign busy            = (r_state != DISP_IDLE) || !w_empty;
  assign drop_count      = r_drop_count;

endmodule

// File: tb/tb_spike_synapse_dispatcher.sv
// Self-checking bench for spike_synapse_dispatcher: directed scenarios plus randomized traffic
// scored against a transaction-level model of the synapse tables.
module tb_spike_synapse_dispatcher;

  localparam int unsigned NUM_SRC    = 16;
  localparam int unsigned FANOUT_MAX = 4;
  localparam int unsigned FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we;
  logic [3:0]  cfg_src;
  logic [1:0]  cfg_slot;
  logic        cfg_en;
  logic [15:0] cfg_dest;
  logic [7:0]  cfg_weight;
  logic        busy;
  logic [15:0] drop_count;
`ifdef DISPATCH_STATS_EN
  logic [31:0] stat_events;
  logic [31:0] stat_syn;
`endif

  always #5 clk = ~clk;

  spike_synapse_dispatcher_if #(.ID_WIDTH(16), .WEIGHT_WIDTH(8)) bus ();

  spike_synapse_dispatcher #(
    .NUM_SRC      (NUM_SRC),
    .FANOUT_MAX   (FANOUT_MAX),
    .ID_WIDTH     (16),
    .WEIGHT_WIDTH (8),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .cfg_we     (cfg_we),
    .cfg_src    (cfg_src),
    .cfg_slot   (cfg_slot),
    .cfg_en     (cfg_en),
    .cfg_dest   (cfg_dest),
    .cfg_weight (cfg_weight),
    .busy       (busy),
    .drop_count (drop_count)
`ifdef DISPATCH_STATS_EN
    ,
    .stat_events (stat_events),
    .stat_syn    (stat_syn)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per-source synapse lists; each accepted event expands into its expected transactions.
  typedef struct {
    logic [15:0] dest;
    logic [15:0] src;
    logic [7:0]  weight;
  } syn_t;

  syn_t        exp_q[$];
  bit          m_en   [NUM_SRC][FANOUT_MAX];
  logic [15:0] m_dest [NUM_SRC][FANOUT_MAX];
  logic [7:0]  m_w    [NUM_SRC][FANOUT_MAX];
  int unsigned m_drops  = 0;
  int unsigned m_events = 0;
  int unsigned n_hs     = 0;

  function automatic void model_clear();
    for (int s = 0; s < NUM_SRC; s++)
      for (int f = 0; f < FANOUT_MAX; f++) begin
        m_en[s][f] = 1'b0; m_dest[s][f] = '0; m_w[s][f] = '0;
      end
    exp_q.delete();
    m_drops = 0;
    m_events = 0;
  endfunction

  function automatic void model_event(input logic [15:0] src);
    if (int'(src) >= NUM_SRC) begin
      if (m_drops < 65535) m_drops++;
    end else begin
      m_events++;
      for (int f = 0; f < FANOUT_MAX; f++)
        if (m_en[src[3:0]][f])
          exp_q.push_back('{dest: m_dest[src[3:0]][f], src: src, weight: m_w[src[3:0]][f]});
    end
  endfunction

  // Monitor: samples between edges, after stimulus settles, to score handshakes and stall stability.
  initial begin
    logic        prev_stall;
    logic [15:0] prev_dest, prev_src;
    logic [7:0]  prev_w;
    syn_t        e;
    prev_stall = 1'b0;
    prev_dest = '0; prev_src = '0; prev_w = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check_eq("stall_valid",  64'(bus.syn_valid), 64'(1));
          check_eq("stall_dest",   64'(bus.syn_dest_id), 64'(prev_dest));
          check_eq("stall_src",    64'(bus.syn_src_id), 64'(prev_src));
          check_eq("stall_weight", 64'(bus.syn_weight), 64'(prev_w));
        end
        if (bus.syn_valid && bus.syn_ready) begin
          n_hs++;
          check_eq("syn_expected", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("syn_dest",   64'(bus.syn_dest_id), 64'(e.dest));
            check_eq("syn_src",    64'(bus.syn_src_id), 64'(e.src));
            check_eq("syn_weight", 64'(bus.syn_weight), 64'(e.weight));
          end
        end
        prev_stall = bus.syn_valid && !bus.syn_ready;
        prev_dest  = bus.syn_dest_id;
        prev_src   = bus.syn_src_id;
        prev_w     = bus.syn_weight;
        if (bus.ev_valid && bus.ev_ready) model_event(bus.ev_src_id);
      end
    end
  end

  task automatic cfg_write(input int unsigned s, input int unsigned f, input int unsigned en,
                           input int unsigned d, input int unsigned w);
    cfg_we = 1'b1; cfg_src = 4'(s); cfg_slot = 2'(f); cfg_en = 1'(en);
    cfg_dest = 16'(d); cfg_weight = 8'(w);
    @(negedge clk);
    cfg_we = 1'b0;
    m_en[s][f] = en[0]; m_dest[s][f] = 16'(d); m_w[s][f] = 8'(w);
  endtask

  task automatic push_event(input int unsigned src);
    bit acc;
    acc = 1'b0;
    bus.ev_valid = 1'b1;
    bus.ev_src_id = 16'(src);
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = bus.ev_ready;
      @(negedge clk);
    end
    bus.ev_valid = 1'b0;
    check_eq("push_accepted", 64'(acc), 64'(1));
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget && busy; k++) @(negedge clk);
    check_eq("idle_reached", 64'(busy), 64'(0));
  endtask

  bit rand_ready_on;

  initial begin
    int unsigned hs0;
    bit seen;
    model_clear();
    bus.ev_valid = 1'b0; bus.ev_src_id = '0; bus.syn_ready = 1'b0;
    cfg_we = 1'b0; cfg_src = '0; cfg_slot = '0; cfg_en = 1'b0; cfg_dest = '0; cfg_weight = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_syn_valid", 64'(bus.syn_valid), 64'(0));
    check_eq("rst_syn_dest",  64'(bus.syn_dest_id), 64'(0));
    check_eq("rst_busy",      64'(busy), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_ev_ready",   64'(bus.ev_ready), 64'(1));
    check_eq("rst_drop_count", 64'(drop_count), 64'(0));
    check_eq("rst_syn_weight", 64'(bus.syn_weight), 64'(0));

    // Row 3: slot0 -> (42,100), slot2 -> (7,200); first output two edges after the push.
    cfg_write(3, 0, 1, 42, 100);
    cfg_write(3, 2, 1, 7, 200);
    bus.syn_ready = 1'b1;
    hs0 = n_hs;
    bus.ev_valid = 1'b1; bus.ev_src_id = 16'd3;
    @(negedge clk);
    bus.ev_valid = 1'b0;
    check_eq("lat_n0_valid", 64'(bus.syn_valid), 64'(0));
    @(negedge clk);
    check_eq("lat_n1_valid", 64'(bus.syn_valid), 64'(0));
    @(negedge clk);
    check_eq("lat_n2_valid",  64'(bus.syn_valid), 64'(1));
    check_eq("lat_n2_dest",   64'(bus.syn_dest_id), 64'(42));
    check_eq("lat_n2_src",    64'(bus.syn_src_id), 64'(3));
    check_eq("lat_n2_weight", 64'(bus.syn_weight), 64'(100));
    wait_idle(50);
    check_eq("row3_hs_count", 64'(n_hs - hs0), 64'(2));
    check_eq("row3_q_empty",  64'(exp_q.size()), 64'(0));

    // Same row with downstream stalled for 5 cycles.
    bus.syn_ready = 1'b0;
    hs0 = n_hs;
    push_event(3);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      seen = bus.syn_valid;
      if (!seen) @(negedge clk);
    end
    check_eq("stall_seen_valid", 64'(seen), 64'(1));
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("hold%0d_dest", k), 64'(bus.syn_dest_id), 64'(42));
      check_eq($sformatf("hold%0d_valid", k), 64'(bus.syn_valid), 64'(1));
      @(negedge clk);
    end
    check_eq("stall_no_hs", 64'(n_hs - hs0), 64'(0));
    bus.syn_ready = 1'b1;
    wait_idle(50);
    check_eq("stall_hs_count", 64'(n_hs - hs0), 64'(2));

    // Fill the FIFO behind a stalled output: rows 5..10 each have only slot1 enabled.
    for (int s = 5; s <= 10; s++) cfg_write(s, 1, 1, 1000 + s, 16 + s);
    bus.syn_ready = 1'b0;
    hs0 = n_hs;
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("fill%0d_ready", i), 64'(bus.ev_ready), 64'(1));
      bus.ev_valid = 1'b1; bus.ev_src_id = 16'(5 + i);
      @(negedge clk);
    end
    bus.ev_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("full%0d_ready", k), 64'(bus.ev_ready), 64'(0));
      check_eq($sformatf("full%0d_busy", k), 64'(busy), 64'(1));
      @(negedge clk);
    end
    bus.syn_ready = 1'b1;
    push_event(10);
    wait_idle(200);
    check_eq("fill_hs_count", 64'(n_hs - hs0), 64'(6));
    check_eq("fill_q_empty",  64'(exp_q.size()), 64'(0));

    // Out-of-range source is dropped; an empty row keeps busy for exactly 5 edges.
    hs0 = n_hs;
    push_event(20);
    wait_idle(20);
    check_eq("drop_count_1", 64'(drop_count), 64'(1));
    bus.ev_valid = 1'b1; bus.ev_src_id = 16'd2;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.ev_valid = 1'b0;
      check_eq($sformatf("empty_row_busy%0d", k), 64'(busy), 64'(k < 5));
    end
    check_eq("empty_row_no_hs", 64'(n_hs - hs0), 64'(0));

    // Randomized traffic with random backpressure; table only rewritten while idle.
    rand_ready_on = 1'b1;
    fork
      begin
        while (rand_ready_on) begin
          @(negedge clk);
          bus.syn_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int r = 0; r < 25; r++) begin
          wait_idle(400);
          repeat (6) cfg_write($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 1),
                               $urandom, $urandom);
          for (int e = 0; e < int'($urandom_range(1, 8)); e++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            push_event($urandom_range(0, 19));
          end
        end
        wait_idle(600);
        rand_ready_on = 1'b0;
      end
    join
    bus.syn_ready = 1'b1;
    @(negedge clk);
    check_eq("rand_q_empty",   64'(exp_q.size()), 64'(0));
    check_eq("rand_drop_count", 64'(drop_count), 64'(m_drops));
`ifdef DISPATCH_STATS_EN
    check_eq("stat_events", 64'(stat_events), 64'(m_events));
    check_eq("stat_syn",    64'(stat_syn), 64'(n_hs));
`endif

    // Reset in the middle of a stalled emission.
    cfg_write(4, 0, 1, 77, 9);
    cfg_write(4, 1, 1, 78, 10);
    bus.syn_ready = 1'b0;
    push_event(4);
    push_event(4);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      seen = bus.syn_valid;
      if (!seen) @(negedge clk);
    end
    check_eq("pre_rst_valid", 64'(seen), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid",    64'(bus.syn_valid), 64'(0));
    check_eq("mid_rst_dest",     64'(bus.syn_dest_id), 64'(0));
    check_eq("mid_rst_ev_ready", 64'(bus.ev_ready), 64'(1));
    check_eq("mid_rst_busy",     64'(busy), 64'(0));
    check_eq("mid_rst_drop",     64'(drop_count), 64'(0));
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.syn_ready = 1'b1;
    hs0 = n_hs;
    push_event(4);
    repeat (10) @(negedge clk);
    check_eq("post_rst_table_clear", 64'(n_hs - hs0), 64'(0));
    check_eq("post_rst_busy",        64'(busy), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
